mem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined RISC-V core. It lets the instruction-fetch (IF) stage and the data (MEM) stage share one unified, word-addressed 64×32 memory. Each cycle it grants at most one requester, drives the memory port and routes the one-cycle-latency read data back to the owner. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 56 +++++
 tb/tb_mem_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data with data priority and bounded fetch starvation
module mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int FAIR_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} owner_e;
  localparam logic [2:0] fair_max_c = 3'(FAIR_MAX);
  owner_e     owner_q, owner_d;
  logic [2:0] streak_q, streak_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= IDLE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end
  // valids are masked by rst so a read in flight when reset rises is dropped
  always_comb begin
    d_gnt     = !rst && d_req && !(if_req && streak_q == fair_max_c);
    if_gnt    = !rst && if_req && !d_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    if_valid  = !rst && owner_q == IF_RD;
    d_valid   = !rst && owner_q == D_RD;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    owner_d   = rst ? IDLE : if_gnt ? IF_RD : !d_gnt ? IDLE : d_we ? D_WR : D_RD;
    streak_d  = (if_gnt || !if_req) ? 3'd0 :
                (d_gnt && streak_q != fair_max_c) ? streak_q + 3'd1 : streak_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a fairness/scoreboard model
module tb_mem_arbiter;
  localparam int FM = 3;
  logic        clk = 0;
  logic        rst, if_req, d_req, d_we;
  logic [5:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [5:0]  mem_addr;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  int total = 0, bad = 0;
  int waits;
  bit pend_if, pend_d;
  logic [31:0] pend_data;
  logic s_if_gnt, s_d_gnt, s_if_valid, s_d_valid, s_mem_en, s_mem_we;
  logic [5:0]  s_mem_addr;
  logic [31:0] s_if_rdata, s_d_rdata;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32), .FAIR_MAX(FM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // waits counts data grants taken while the fetch was left waiting
  task automatic cyc(input bit r, input bit iq, input int ia, input bit dq, input bit dw,
                     input int da, input logic [31:0] wd);
    bit exp_d, exp_if;
    rst = r; if_req = iq; if_addr = 6'(ia); d_req = dq; d_we = dw; d_addr = 6'(da); d_wdata = wd;
    @(negedge clk);
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_valid = if_valid; s_d_valid = d_valid;
    s_mem_en = mem_en; s_mem_we = mem_we; s_mem_addr = mem_addr;
    s_if_rdata = if_rdata; s_d_rdata = d_rdata;
    exp_d  = !r && dq && !(iq && waits >= FM);
    exp_if = !r && iq && !exp_d;
    chk("d_gnt", 32'(d_gnt), 32'(exp_d));
    chk("if_gnt", 32'(if_gnt), 32'(exp_if));
    chk("mem_en", 32'(mem_en), 32'(exp_d || exp_if));
    chk("mem_we", 32'(mem_we), 32'(exp_d && dw));
    chk("mem_addr", 32'(mem_addr), exp_d ? 32'(da) : exp_if ? 32'(ia) : 32'd0);
    if (exp_d && dw) chk("mem_wdata", mem_wdata, wd);
    if (!exp_d && !exp_if) chk("mem_wdata_idle", mem_wdata, 32'd0);
    chk("if_valid", 32'(if_valid), 32'(pend_if && !r));
    chk("d_valid", 32'(d_valid), 32'(pend_d && !r));
    if (pend_if && !r) chk("if_rdata", if_rdata, pend_data);
    if (pend_d && !r) chk("d_rdata", d_rdata, pend_data);
    pend_if = exp_if;
    pend_d  = exp_d && !dw;
    pend_data = exp_if ? shadow[6'(ia)] : shadow[6'(da)];
    if (exp_d && dw) shadow[6'(da)] = wd;
    if (r || !iq || exp_if) waits = 0;
    else if (exp_d && waits < FM) waits++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[5] = 32'h002081b3; shadow[5] = 32'h002081b3;
    waits = 0; pend_if = 0; pend_d = 0; pend_data = '0;
    cyc(1, 1, 1, 1, 0, 2, 0);
    cyc(1, 1, 1, 1, 0, 2, 0);
    chk("rst_gnt", 32'({s_if_gnt, s_d_gnt, s_mem_en}), 32'd0);
    chk("rst_valid", 32'({s_if_valid, s_d_valid}), 32'd0);
    chk("rst_streak", 32'(dut.streak_q), 32'd0);
    cyc(0, 1, 5, 0, 0, 0, 0);
    chk("fetch_gnt", 32'(s_if_gnt), 32'd1);
    chk("fetch_addr", 32'(s_mem_addr), 32'd5);
    idle();
    chk("fetch_valid", 32'(s_if_valid), 32'd1);
    chk("fetch_data", s_if_rdata, 32'h002081b3);
    chk("fetch_dvalid", 32'(s_d_valid), 32'd0);
    cyc(0, 0, 0, 1, 1, 3, 32'hDEADBEEF);
    chk("st_we", 32'(s_mem_we), 32'd1);
    cyc(0, 0, 0, 1, 0, 3, 0);
    chk("st_novalid", 32'(s_d_valid), 32'd0);
    idle();
    chk("ld_valid", 32'(s_d_valid), 32'd1);
    chk("ld_data", s_d_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, i, 1, 0, 10 + i, 0);
      chk("cont_d", 32'(s_d_gnt), 32'(i % 4 != 3));
      if (i % 4 == 0 && i > 0) chk("cont_ifvalid", 32'(s_if_valid), 32'd1);
    end
    idle();
    chk("cont_last_ifvalid", 32'(s_if_valid), 32'd1);
    cyc(0, 1, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 0, 1, 0);
      chk("clr_d", 32'(s_d_gnt), 32'(i != 3));
    end
    idle();
    cyc(0, 0, 0, 1, 0, 7, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rstrd_v1", 32'(s_d_valid), 32'd0);
    idle();
    chk("rstrd_v2", 32'(s_d_valid), 32'd0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(63),
          $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(63), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
